// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one ALU op at a time, waits an op-dependent settle time, holds the response until taken.
// Optional ALU_DIVZERO_CHK_EN: divide-by-zero and illegal ops are flagged on rsp_err.
module alu_issue_ctrl #(
    parameter int MUL_WAIT = 4,
    parameter int DIV_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [2:0]  req_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_op_select,
    output logic        alu_sub,
    input  logic [15:0] alu_result,
    input  logic        alu_cout,
    input  logic        alu_overflow,
    input  logic        alu_no,
    input  logic        alu_zo,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_cout,
    output logic        rsp_overflow,
    output logic        rsp_neg,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t      state, state_nxt;
    logic [3:0]  cnt, w_load;
    logic [15:0] a_q, b_q;
    logic [2:0]  op_q;
    logic        accept, capture, arith, illegal, div_zero;
    logic [15:0] res_cap;
    assign accept        = req_valid && state == IDLE;
    assign capture       = state == WAIT && cnt == 4'd1;
    assign arith         = op_q == 3'd0 || op_q == 3'd1;
    assign illegal       = op_q[2:1] == 2'b11;
    assign req_ready     = state == IDLE;
    assign rsp_valid     = state == DONE;
    assign busy          = state != IDLE;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_op_select = op_q;
    assign alu_sub       = op_q == 3'd1;
`ifdef ALU_DIVZERO_CHK_EN
    assign div_zero = op_q == 3'd5 && b_q == 16'd0;
    assign w_load   = req_op == 3'd4 ? 4'(MUL_WAIT) :
                      req_op == 3'd5 ? (req_b == 16'd0 ? 4'd1 : 4'(DIV_WAIT)) : 4'd1;
`else
    assign div_zero = 1'b0;
    assign w_load   = req_op == 3'd4 ? 4'(MUL_WAIT) : req_op == 3'd5 ? 4'(DIV_WAIT) : 4'd1;
`endif
    assign res_cap = illegal ? 16'h0000 : div_zero ? 16'hFFFF : alu_result;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req_valid ? WAIT : IDLE;
            WAIT:    state_nxt = cnt == 4'd1 ? DONE : WAIT;
            DONE:    state_nxt = rsp_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 4'd0;
            a_q  <= 16'd0;
            b_q  <= 16'd0;
            op_q <= 3'd0;
        end else if (accept) begin
            cnt  <= w_load;
            a_q  <= req_a;
            b_q  <= req_b;
            op_q <= req_op;
        end else if (state == WAIT) begin
            cnt  <= cnt - 4'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result   <= 16'd0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_neg      <= 1'b0;
            rsp_zero     <= 1'b0;
        end else if (capture) begin
            rsp_result   <= res_cap;
            rsp_cout     <= arith && alu_cout;
            rsp_overflow <= arith && alu_overflow;
            rsp_neg      <= arith && alu_no;
            rsp_zero     <= arith && alu_zo;
        end
    end
`ifdef ALU_DIVZERO_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rsp_err <= 1'b0;
        else if (capture) rsp_err <= illegal || div_zero;
    end
`else
    assign rsp_err = 1'b0;
`endif
endmodule
